forward_mul_pipe_sat: RTL and testbench
=======================================

Name: forward_mul_pipe_sat

Overview:
Parametrised, pipelined multiplier for the forward-pass datapath. It is the successor to the single-cycle combinational multipliers. It adds:
- configurable pipeline depth
- valid/ready flow control and clock enable
- signed/unsigned mode
- fixed-point right shift with round-half-up
- saturating or wrapping output narrowing, with a per-beat overflow flag

It sits between operand fetch and the accumulator stage of the forward network.

Parameters:
ID, 1, instance identifier; no functional effect.
NUM_STAGE, 3, pipeline register stages (>=1); latency in unstalled cycles.
din0_WIDTH, 13, width of operand 0.
din1_WIDTH, 71, width of operand 1.
dout_WIDTH, 71, width of result.
SIGNED, 1, 1 = two's-complement operands/result; 0 = unsigned.
FRAC_SHIFT, 0, right shift applied to the full product before narrowing (0 = none).
SATURATE, 1, 1 = clamp out-of-range results; 0 = truncate (wrap).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
ce  in  1  clock enable; 0 freezes all state.
in_valid  in  1  operand beat valid.
in_ready  out  1  block accepts a beat this cycle.
din0  in  din0_WIDTH  operand 0.
din1  in  din1_WIDTH  operand 1.
out_valid  out  1  dout/ovf hold a valid result.
out_ready  in  1  downstream accepts the result.
dout  out  dout_WIDTH  rounded, narrowed product.
ovf  out  1  result was out of range for this beat (valid with out_valid).

Behaviour:
- P = din0_WIDTH + din1_WIDTH. The full product is exact at P bits, signed or unsigned per SIGNED.
- advance = ce & (~out_valid | out_ready); in_ready = advance, combinational.
- When advance = 1:
  - Every stage shifts forward one position.
  - Stage 1 captures din0/din1 with valid = in_valid.
  - Bubbles propagate as invalid stages; no compaction.
- When advance = 0, all stages hold.
- Throughput 1 beat/cycle. Latency from acceptance to out_valid is exactly NUM_STAGE cycles when unstalled.
- Multiply, round and narrow may be distributed across stages in any way. Results and timing at the output must be identical for any split.
- Rounding, when FRAC_SHIFT > 0:
  - r = (p + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed at P+1 bits.
  - The shift is arithmetic if SIGNED, logical otherwise.
  - When FRAC_SHIFT = 0, r = p.
- Range check against dout_WIDTH:
  - signed: [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]
  - unsigned: [0, 2^dout_WIDTH-1]
- If r is outside the range, ovf = 1. dout is clamped to the nearest bound when SATURATE = 1, or takes the low dout_WIDTH bits of r when SATURATE = 0.
- If dout_WIDTH >= P+1, the range check is trivially passed and ovf is always 0.
- dout and ovf change only when out_valid rises or a new beat is presented. They are stable while out_valid & ~out_ready.
- A beat is consumed on any cycle with out_valid & out_ready & ce.
- Simultaneous consume and accept in the same cycle is legal; full throughput is maintained.
- ce = 0 overrides everything: no accept, no consume, all outputs hold. in_ready = 0.
- reset = 1 at a clock edge:
  - All stage valid bits are cleared, so out_valid = 0, dout = 0 and ovf = 0 on the next cycle.
  - In-flight beats are discarded, regardless of ce.
  - in_ready is 1 the cycle after reset if ce = 1.
- Operand values when in_valid = 0 are don't-care and must not affect any output.

Test Plan:
(Configuration for all scenarios: din0_WIDTH = din1_WIDTH = dout_WIDTH = 8, NUM_STAGE = 3, unless noted.)
1. SIGNED=1, FRAC_SHIFT=0, beat din0=-3, din1=5 at cycle 0, out_ready=1 -> out_valid at cycle 3, dout=0xF1 (-15), ovf=0, single cycle.
2. SIGNED=1, SATURATE=1: 100*100 -> dout=127, ovf=1. -128*127 -> dout=-128, ovf=1. With SATURATE=0, 100*100 -> dout=0x10, ovf=1.
3. FRAC_SHIFT=4: 7*5=35 -> dout=2. -7*5=-35 -> dout=-2. 8*1=8 -> dout=1 (half rounds up). All with ovf=0.
4. Stream 6 back-to-back beats, drop out_ready for cycles 4-5 -> in_ready=0 during the stall, dout stable, all 6 results delivered in order with no loss or duplication, and full rate resumes afterwards.
5. ce=0 for 2 cycles mid-stream -> no state change and no handshakes. Then assert reset with 2 beats in flight -> out_valid=0 the next cycle, and neither beat ever appears.
6. SIGNED=0, SATURATE=1: 255*255 -> dout=255, ovf=1. 15*17 -> dout=255, ovf=0. Separately, NUM_STAGE=1 -> latency 1 cycle.

Source files
------------

// File: rtl/forward_mul_pipe_sat.sv
// forward_mul_pipe_sat
// Pipelined multiplier for the forward-pass datapath, placed between operand
// fetch and the accumulator stage. It forms the exact din0*din1 product
// (signed or unsigned), optionally rounds it half-up and shifts it right by
// FRAC_SHIFT, then narrows it to dout_WIDTH bits. Narrowing either saturates
// or wraps, and ovf flags results that were out of range.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; drops every in-flight beat
//   ce         clock enable; 0 freezes all state and blocks handshakes
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational)
//   din0/din1  operands
//   out_valid  dout/ovf hold a result
//   out_ready  downstream takes the result
//   dout       rounded, narrowed product
//   ovf        result was out of range for dout_WIDTH

module forward_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 71,
  parameter int dout_WIDTH = 71,
  parameter int SIGNED     = 1,
  parameter int FRAC_SHIFT = 0,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P   = din0_WIDTH + din1_WIDTH;
  localparam int RW  = P + 1;
  localparam int DW  = dout_WIDTH;
  localparam bit SGN = (SIGNED != 0);
  localparam bit SAT = (SATURATE != 0);

  logic [NUM_STAGE-1:0]  vld;
  logic                  advance;
  logic [din0_WIDTH-1:0] op0_q;
  logic [din1_WIDTH-1:0] op1_q;
  logic [P-1:0]          a_ext;
  logic [P-1:0]          b_ext;
  logic [P-1:0]          prod;
  logic [RW-1:0]         p_ext;
  logic [RW-1:0]         r;
  logic [DW-1:0]         dout_c;
  logic                  ovf_c;

  // The whole pipe moves as one unit: it advances only when the output slot
  // is empty or is being drained this cycle, so in_ready is just that
  // condition.
  assign out_valid = vld[NUM_STAGE-1];
  assign advance   = ce & (~out_valid | out_ready);
  assign in_ready  = advance;

  // Valid bits shift every time the pipe advances. Bubbles are carried as
  // invalid stages so latency stays fixed at NUM_STAGE cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else if (advance) begin
      vld[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Stage 1 holds the operands. They load only for a real beat, so operand
  // values presented without in_valid never reach the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      op0_q <= '0;
      op1_q <= '0;
    end else if (advance && in_valid) begin
      op0_q <= din0;
      op1_q <= din1;
    end
  end

  // Both operands are extended to the full product width. The low P bits of
  // the product are then exact for either signedness, so one unsigned
  // multiplier covers both modes.
  assign a_ext = {{din1_WIDTH{SGN & op0_q[din0_WIDTH-1]}}, op0_q};
  assign b_ext = {{din0_WIDTH{SGN & op1_q[din1_WIDTH-1]}}, op1_q};
  assign prod  = a_ext * b_ext;

  // One extra bit of headroom so that adding the rounding constant cannot
  // overflow.
  assign p_ext = {SGN & prod[P-1], prod};

  // Round half-up: add half an LSB of the shifted result, then shift
  // arithmetically for signed data and logically for unsigned data.
  if (FRAC_SHIFT == 0) begin : g_noround
    assign r = p_ext;
  end else begin : g_round
    localparam logic [RW-1:0] HALF = RW'(1) << (FRAC_SHIFT - 1);
    logic [RW-1:0] sum;
    assign sum = p_ext + HALF;
    if (SGN) begin : g_ashr
      logic signed [RW-1:0] sum_s;
      assign sum_s = sum;
      assign r     = sum_s >>> FRAC_SHIFT;
    end else begin : g_lshr
      assign r = sum >> FRAC_SHIFT;
    end
  end

  // Narrowing. A signed value fits when all bits from the dout sign bit
  // upwards agree. An unsigned value fits when everything above dout is zero.
  // An output as wide as the rounded value always fits.
  if (DW >= RW) begin : g_wide
    assign ovf_c = 1'b0;
    if (DW == RW) begin : g_same
      assign dout_c = r;
    end else begin : g_ext
      assign dout_c = {{(DW-RW){SGN & r[RW-1]}}, r};
    end
  end else if (SGN) begin : g_snarrow
    logic in_range;
    assign in_range = (&r[RW-1:DW-1]) | ~(|r[RW-1:DW-1]);
    assign ovf_c    = ~in_range;
    always_comb begin
      dout_c = r[DW-1:0];
      if (!in_range && SAT) begin
        dout_c = r[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end
  end else begin : g_unarrow
    logic in_range;
    assign in_range = ~(|r[RW-1:DW]);
    assign ovf_c    = ~in_range;
    always_comb begin
      dout_c = r[DW-1:0];
      if (!in_range && SAT) begin
        dout_c = '1;
      end
    end
  end

  // The remaining NUM_STAGE-1 stages carry the finished result. Each stage
  // loads only when the stage behind it holds a valid beat, so dout keeps its
  // last value while bubbles pass through.
  if (NUM_STAGE == 1) begin : g_single
    assign dout = dout_c;
    assign ovf  = ovf_c;
  end else begin : g_multi
    logic [DW-1:0] dq [NUM_STAGE-1];
    logic          oq [NUM_STAGE-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) begin
          dq[i] <= '0;
          oq[i] <= 1'b0;
        end
      end else if (advance) begin
        if (vld[0]) begin
          dq[0] <= dout_c;
          oq[0] <= ovf_c;
        end
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          if (vld[i]) begin
            dq[i] <= dq[i-1];
            oq[i] <= oq[i-1];
          end
        end
      end
    end

    assign dout = dq[NUM_STAGE-2];
    assign ovf  = oq[NUM_STAGE-2];
  end

endmodule

// File: tb/tb_forward_mul_pipe_sat.sv
// tb_forward_mul_pipe_sat
// Directed bench for forward_mul_pipe_sat. Five 8x8->8 instances share one
// set of inputs:
//   s: signed, saturating, 3 stages
//   w: signed, wrapping, 3 stages
//   f: signed, saturating, FRAC_SHIFT=4, 3 stages
//   u: unsigned, saturating, 3 stages
//   n: signed, saturating, 1 stage
// A table of single beats with hand-computed results exercises the
// arithmetic. Hand-written sequences then cover backpressure, clock enable and
// reset.

module tb_forward_mul_pipe_sat;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ds;
    logic       os;
    logic [7:0] dw;
    logic       ow;
    logic [7:0] df;
    logic       of_;
    logic [7:0] du;
    logic       ou;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] din0;
  logic [7:0] din1;

  logic       rdy_s, ov_s, f_s;
  logic [7:0] d_s;
  logic       rdy_w, ov_w, f_w;
  logic [7:0] d_w;
  logic       rdy_f, ov_f, f_f;
  logic [7:0] d_f;
  logic       rdy_u, ov_u, f_u;
  logic [7:0] d_u;
  logic       rdy_n, ov_n, f_n;
  logic [7:0] d_n;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [11];

  always #5 clk = ~clk;

  forward_mul_pipe_sat #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8),
    .dout_WIDTH(8), .SIGNED(1), .FRAC_SHIFT(0), .SATURATE(1)) u_s (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_s),
    .din0(din0), .din1(din1), .out_valid(ov_s), .out_ready(out_ready),
    .dout(d_s), .ovf(f_s));

  forward_mul_pipe_sat #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8),
    .dout_WIDTH(8), .SIGNED(1), .FRAC_SHIFT(0), .SATURATE(0)) u_w (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_w),
    .din0(din0), .din1(din1), .out_valid(ov_w), .out_ready(out_ready),
    .dout(d_w), .ovf(f_w));

  forward_mul_pipe_sat #(.ID(3), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8),
    .dout_WIDTH(8), .SIGNED(1), .FRAC_SHIFT(4), .SATURATE(1)) u_f (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_f),
    .din0(din0), .din1(din1), .out_valid(ov_f), .out_ready(out_ready),
    .dout(d_f), .ovf(f_f));

  forward_mul_pipe_sat #(.ID(4), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8),
    .dout_WIDTH(8), .SIGNED(0), .FRAC_SHIFT(0), .SATURATE(1)) u_u (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_u),
    .din0(din0), .din1(din1), .out_valid(ov_u), .out_ready(out_ready),
    .dout(d_u), .ovf(f_u));

  forward_mul_pipe_sat #(.ID(5), .NUM_STAGE(1), .din0_WIDTH(8), .din1_WIDTH(8),
    .dout_WIDTH(8), .SIGNED(1), .FRAC_SHIFT(0), .SATURATE(1)) u_n (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_n),
    .din0(din0), .din1(din1), .out_valid(ov_n), .out_ready(out_ready),
    .dout(d_n), .ovf(f_n));

  // Drive one operand beat, or a bubble with junk operands.
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    din0     = a;
    din1     = b;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         tx;
    int         rx;
    int         last_c;
    logic       held_v;
    logic [7:0] held;

    // Fields: a, b, then {dout, ovf} for the s, w, f and u instances.
    vecs[0]  = '{8'hFD, 8'h05, 8'hF1, 1'b0, 8'hF1, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[1]  = '{8'h64, 8'h64, 8'h7F, 1'b1, 8'h10, 1'b1, 8'h7F, 1'b1, 8'hFF, 1'b1};
    vecs[2]  = '{8'h80, 8'h7F, 8'h80, 1'b1, 8'h80, 1'b1, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{8'h07, 8'h05, 8'h23, 1'b0, 8'h23, 1'b0, 8'h02, 1'b0, 8'h23, 1'b0};
    vecs[4]  = '{8'hF9, 8'h05, 8'hDD, 1'b0, 8'hDD, 1'b0, 8'hFE, 1'b0, 8'hFF, 1'b1};
    vecs[5]  = '{8'h08, 8'h01, 8'h08, 1'b0, 8'h08, 1'b0, 8'h01, 1'b0, 8'h08, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1};
    vecs[7]  = '{8'h0F, 8'h11, 8'h7F, 1'b1, 8'hFF, 1'b1, 8'h10, 1'b0, 8'hFF, 1'b0};
    vecs[8]  = '{8'hF8, 8'h01, 8'hF8, 1'b0, 8'hF8, 1'b0, 8'h00, 1'b0, 8'hF8, 1'b0};
    vecs[9]  = '{8'h80, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 8'h7F, 1'b1, 8'hFF, 1'b1};
    vecs[10] = '{8'h80, 8'hFF, 8'h7F, 1'b1, 8'h80, 1'b1, 8'h08, 1'b0, 8'hFF, 1'b1};

    reset     = 1'b1;
    ce        = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset out_valid", ov_s, 0);
    checkOutput("reset dout", d_s, 0);
    checkOutput("reset ovf", f_s, 0);
    checkOutput("reset in_ready", rdy_s, 1);
    checkOutput("reset n dout", d_n, 0);

    // Single beats: 1-stage result after one edge, 3-stage after three,
    // each held for exactly one cycle.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[i].a, vecs[i].b);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        #1;
        if (k == 1) begin
          applyStimulus(1'b0, 8'($urandom), 8'($urandom));
          checkOutput($sformatf("v%0d n valid", i), ov_n, 1);
          checkOutput($sformatf("v%0d n dout", i), d_n, vecs[i].ds);
          checkOutput($sformatf("v%0d n ovf", i), f_n, vecs[i].os);
        end
        if (k == 2) begin
          checkOutput($sformatf("v%0d n valid drop", i), ov_n, 0);
        end
        if (k != 3) begin
          checkOutput($sformatf("v%0d s valid k%0d", i, k), ov_s, 0);
        end else begin
          checkOutput($sformatf("v%0d s valid", i), ov_s, 1);
          checkOutput($sformatf("v%0d s dout", i), d_s, vecs[i].ds);
          checkOutput($sformatf("v%0d s ovf", i), f_s, vecs[i].os);
          checkOutput($sformatf("v%0d w valid", i), ov_w, 1);
          checkOutput($sformatf("v%0d w dout", i), d_w, vecs[i].dw);
          checkOutput($sformatf("v%0d w ovf", i), f_w, vecs[i].ow);
          checkOutput($sformatf("v%0d f valid", i), ov_f, 1);
          checkOutput($sformatf("v%0d f dout", i), d_f, vecs[i].df);
          checkOutput($sformatf("v%0d f ovf", i), f_f, vecs[i].of_);
          checkOutput($sformatf("v%0d u valid", i), ov_u, 1);
          checkOutput($sformatf("v%0d u dout", i), d_u, vecs[i].du);
          checkOutput($sformatf("v%0d u ovf", i), f_u, vecs[i].ou);
        end
      end
    end

    // Six back-to-back beats with out_ready low on cycles 4 and 5.
    tx     = 0;
    rx     = 0;
    last_c = -1;
    held_v = 1'b0;
    held   = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c == 4 || c == 5);
      #1;
      if (held_v) begin
        checkOutput($sformatf("stall dout stable c%0d", c), d_s, held);
      end
      held_v = ov_s && !out_ready;
      held   = d_s;
      if (c == 4 || c == 5) begin
        checkOutput($sformatf("stall in_ready c%0d", c), rdy_s, 0);
      end
      if (ov_s && out_ready) begin
        if (rx < 6) begin
          checkOutput($sformatf("stream beat%0d dout", rx), d_s, vecs[rx].ds);
        end else begin
          checkOutput("stream duplicate beat", rx, 5);
        end
        rx++;
        last_c = c;
      end
      if (tx < 6) begin
        applyStimulus(1'b1, vecs[tx].a, vecs[tx].b);
      end else begin
        applyStimulus(1'b0, 8'($urandom), 8'($urandom));
      end
      if (in_valid && rdy_s) begin
        tx++;
      end
    end
    checkOutput("stream delivered", rx, 6);
    checkOutput("stream accepted", tx, 6);
    checkOutput("stream last beat cycle", last_c, 10);

    // Clock enable freeze, then reset with two beats in flight.
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, vecs[3].a, vecs[3].b);
    @(negedge clk);
    applyStimulus(1'b1, vecs[5].a, vecs[5].b);
    @(negedge clk);
    applyStimulus(1'b0, 8'($urandom), 8'($urandom));
    @(negedge clk);
    ce = 1'b0;
    applyStimulus(1'b1, vecs[1].a, vecs[1].b);
    #1;
    checkOutput("ce0 valid c3", ov_s, 1);
    checkOutput("ce0 dout c3", d_s, 8'h23);
    checkOutput("ce0 in_ready", rdy_s, 0);
    @(negedge clk);
    #1;
    checkOutput("ce0 valid c4", ov_s, 1);
    checkOutput("ce0 dout c4", d_s, 8'h23);
    checkOutput("ce0 in_ready c4", rdy_s, 0);
    @(negedge clk);
    ce = 1'b1;
    applyStimulus(1'b0, 8'($urandom), 8'($urandom));
    #1;
    checkOutput("ce1 valid c5", ov_s, 1);
    checkOutput("ce1 dout c5", d_s, 8'h23);
    @(negedge clk);
    #1;
    checkOutput("ce1 valid c6", ov_s, 1);
    checkOutput("ce1 dout c6", d_s, 8'h08);
    @(negedge clk);
    #1;
    checkOutput("ce0 beat not taken", ov_s, 0);
    applyStimulus(1'b1, vecs[1].a, vecs[1].b);
    @(negedge clk);
    applyStimulus(1'b1, vecs[8].a, vecs[8].b);
    @(negedge clk);
    applyStimulus(1'b0, 8'($urandom), 8'($urandom));
    reset = 1'b1;
    ce    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ce    = 1'b1;
    #1;
    checkOutput("flush valid", ov_s, 0);
    checkOutput("flush dout", d_s, 0);
    checkOutput("flush ovf", f_s, 0);
    checkOutput("flush in_ready", rdy_s, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("flushed beat absent c%0d", c), ov_s, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
